// File: rtl/vga_timing_controller.sv
// VGA raster timing: horizontal/vertical counters stepped through phase FSMs,
// with registered syncs, display enable and line/frame strobes aligned to the counters.
module vga_timing_controller #(
  parameter int COUNTER_SIZE    = 11,
  parameter int H_ACTIVE        = 1024,
  parameter int H_FRONT         = 24,
  parameter int H_SYNC          = 136,
  parameter int H_BACK          = 144,
  parameter int V_ACTIVE        = 768,
  parameter int V_FRONT         = 3,
  parameter int V_SYNC          = 6,
  parameter int V_BACK          = 29,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                    control_clock,
  input  logic                    control_reset_n,
  input  logic                    run,
  output logic                    busy,
  output logic [COUNTER_SIZE-1:0] h_count,
  output logic [COUNTER_SIZE-1:0] v_count,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    display_enable,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int CS = COUNTER_SIZE;

  localparam logic [CS-1:0] H_ACT_END = CS'(H_ACTIVE - 1);
  localparam logic [CS-1:0] H_FP_END  = CS'(H_ACTIVE + H_FRONT - 1);
  localparam logic [CS-1:0] H_SY_END  = CS'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CS-1:0] H_LAST    = CS'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CS-1:0] V_ACT_END = CS'(V_ACTIVE - 1);
  localparam logic [CS-1:0] V_FP_END  = CS'(V_ACTIVE + V_FRONT - 1);
  localparam logic [CS-1:0] V_SY_END  = CS'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CS-1:0] V_LAST    = CS'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CS-1:0] ONE       = CS'(1);

  localparam logic [0:0] ST_IDLE = 1'd0;
  localparam logic [0:0] ST_SCAN = 1'd1;

  // Shared encoding for both phase FSMs: active, front porch, sync, back porch.
  localparam logic [1:0] PH_ACT = 2'd0;
  localparam logic [1:0] PH_FP  = 2'd1;
  localparam logic [1:0] PH_SY  = 2'd2;
  localparam logic [1:0] PH_BP  = 2'd3;

  logic [0:0]    state_q, state_d;
  logic [CS-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]    hph_q, hph_d, vph_q, vph_d;
  logic [1:0]    hph_nx, vph_nx;
  logic          h_last, v_last, scan_d;

  logic busy_q, hs_q, vs_q, de_q, ls_q, fs_q;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    hph_nx = hph_q;
    case (hph_q)
      PH_ACT:  if (h_q == H_ACT_END) hph_nx = PH_FP;
      PH_FP:   if (h_q == H_FP_END)  hph_nx = PH_SY;
      PH_SY:   if (h_q == H_SY_END)  hph_nx = PH_BP;
      default: if (h_last)           hph_nx = PH_ACT;
    endcase
  end

  always_comb begin
    vph_nx = vph_q;
    case (vph_q)
      PH_ACT:  if (v_q == V_ACT_END) vph_nx = PH_FP;
      PH_FP:   if (v_q == V_FP_END)  vph_nx = PH_SY;
      PH_SY:   if (v_q == V_SY_END)  vph_nx = PH_BP;
      default: if (v_last)           vph_nx = PH_ACT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    hph_d   = hph_q;
    vph_d   = vph_q;
    case (state_q)
      ST_IDLE: begin
        h_d   = '0;
        v_d   = '0;
        hph_d = PH_ACT;
        vph_d = PH_ACT;
        if (run) state_d = ST_SCAN;
      end
      default: begin
        // run only matters on the final pixel, so a frame is never cut short.
        if (h_last && v_last && !run) begin
          state_d = ST_IDLE;
          h_d     = '0;
          v_d     = '0;
          hph_d   = PH_ACT;
          vph_d   = PH_ACT;
        end else begin
          h_d   = h_last ? '0 : h_q + ONE;
          hph_d = hph_nx;
          if (h_last) begin
            v_d   = v_last ? '0 : v_q + ONE;
            vph_d = vph_nx;
          end
        end
      end
    endcase
  end

  assign scan_d = (state_d == ST_SCAN);

  // Outputs are computed from next-state values so they line up with the counters.
  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hph_q   <= PH_ACT;
      vph_q   <= PH_ACT;
      busy_q  <= 1'b0;
      hs_q    <= SYNC_ACTIVE_LOW;
      vs_q    <= SYNC_ACTIVE_LOW;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      busy_q  <= scan_d;
      hs_q    <= (scan_d && (hph_d == PH_SY)) ^ SYNC_ACTIVE_LOW;
      vs_q    <= (scan_d && (vph_d == PH_SY)) ^ SYNC_ACTIVE_LOW;
      de_q    <= scan_d && (hph_d == PH_ACT) && (vph_d == PH_ACT);
      ls_q    <= scan_d && (h_d == '0);
      fs_q    <= scan_d && (h_d == '0) && (v_d == '0);
    end
  end

  assign busy           = busy_q;
  assign h_count        = h_q;
  assign v_count        = v_q;
  assign h_sync         = hs_q;
  assign v_sync         = vs_q;
  assign display_enable = de_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a shrunken 16x8 raster, with an
// active-low and an active-high instance driven from the same inputs.
module tb_vga_timing_controller;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run;

  logic          a_busy, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [CW-1:0] a_h, a_v;
  logic          b_busy, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [CW-1:0] b_h, b_v;

  vga_timing_controller #(
    .COUNTER_SIZE(CW), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE_LOW(1'b1)
  ) dut_a (
    .control_clock(clk), .control_reset_n(rst_n), .run(run), .busy(a_busy),
    .h_count(a_h), .v_count(a_v), .h_sync(a_hs), .v_sync(a_vs),
    .display_enable(a_de), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_controller #(
    .COUNTER_SIZE(CW), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .control_clock(clk), .control_reset_n(rst_n), .run(run), .busy(b_busy),
    .h_count(b_h), .v_count(b_v), .h_sync(b_hs), .v_sync(b_vs),
    .display_enable(b_de), .line_start(b_ls), .frame_start(b_fs)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit m_busy = 1'b0;
  int m_h    = 0;
  int m_v    = 0;

  bit measure = 1'b0;
  int last_fs = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model of one rising edge, evaluated with the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_busy) begin
      if (run) begin m_busy = 1'b1; m_h = 0; m_v = 0; end
    end else if (m_h == HT - 1 && m_v == VT - 1 && !run) begin
      m_busy = 1'b0; m_h = 0; m_v = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic check_all();
    bit hs_act, vs_act, de, ls, fs;
    hs_act = m_busy && m_h >= HA + HF && m_h < HA + HF + HS;
    vs_act = m_busy && m_v >= VA + VF && m_v < VA + VF + VS;
    de     = m_busy && m_h < HA && m_v < VA;
    ls     = m_busy && m_h == 0;
    fs     = m_busy && m_h == 0 && m_v == 0;
    check("busy",     32'(a_busy), 32'(m_busy));
    check("h_count",  32'(a_h),    32'(m_h));
    check("v_count",  32'(a_v),    32'(m_v));
    check("h_sync",   32'(a_hs),   32'(!hs_act));
    check("v_sync",   32'(a_vs),   32'(!vs_act));
    check("de",       32'(a_de),   32'(de));
    check("line_st",  32'(a_ls),   32'(ls));
    check("frame_st", 32'(a_fs),   32'(fs));
    check("h_sync_hi", 32'(b_hs),  32'(hs_act));
    check("v_sync_hi", 32'(b_vs),  32'(vs_act));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_all();
    if (measure && a_fs) begin
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
      last_fs = cyc;
    end
  endtask

  initial begin
    int vs_low, de_bad;
    rst_n = 1'b0;
    run   = 1'b1;

    // Reset held with run asserted: reset must win.
    repeat (3) step();

    // Start and two continuous frames.
    rst_n   = 1'b1;
    measure = 1'b1;
    vs_low  = 0;
    de_bad  = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      if (a_vs == 1'b0) vs_low++;
      if (a_de && a_v >= CW'(VA)) de_bad++;
    end
    check("vs_low_cycles", 32'(vs_low), 32'(2 * VS * HT));
    check("de_in_vblank",  32'(de_bad), 32'(0));
    measure = 1'b0;
    step();
    check("wrap_no_gap_fs", 32'(a_fs), 32'(1));

    // Drop run mid-frame; the frame must complete before idling.
    for (int i = 0; i < 300 && !(m_h == 4 && m_v == 2); i++) step();
    check("stop_point_h", 32'(a_h), 32'(4));
    check("stop_point_v", 32'(a_v), 32'(2));
    run = 1'b0;
    for (int i = 0; i < 300 && m_busy; i++) step();
    check("stopped_busy", 32'(a_busy), 32'(0));
    repeat (4) step();
    run = 1'b1;
    step();
    check("restart_fs", 32'(a_fs), 32'(1));

    // Reset in the middle of both sync pulses.
    for (int i = 0; i < 300 && !(m_h == HA + HF + 1 && m_v == VA + VF); i++) step();
    check("pre_rst_hsync", 32'(a_hs), 32'(0));
    check("pre_rst_vsync", 32'(a_vs), 32'(0));
    rst_n = 1'b0;
    step();
    check("mid_rst_busy",  32'(a_busy), 32'(0));
    check("mid_rst_hsync", 32'(a_hs),   32'(1));
    check("mid_rst_vsync_hi", 32'(b_vs), 32'(0));
    rst_n = 1'b1;
    run   = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Sequencing controller for the VGA raster scan in the display pipeline. It owns the horizontal and vertical pixel counters and steps each through its active, front-porch, sync and back-porch phases. It drives sync, display-enable, coordinate and start-of-line/frame strobes to the pixel datapath. A run/stop handshake starts and stops scanning only on frame boundaries.

## Interface
Parameters:
- COUNTER_SIZE, 11, width of both position counters
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 144, horizontal back porch (pixels); line total = 1328
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines); frame total = 806
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are driven low, 0 = driven high

Ports:
- control_clock, in, 1, pixel clock; all state changes on its rising edge
- control_reset_n, in, 1, synchronous active-low reset
- run, in, 1, level request: 1 = scan frames, 0 = stop at end of the current frame
- busy, out, 1, 1 while a frame is in progress
- h_count, out, COUNTER_SIZE, horizontal position, 0..1327
- v_count, out, COUNTER_SIZE, vertical position, 0..805
- h_sync, out, 1, horizontal sync, polarity set by SYNC_ACTIVE_LOW
- v_sync, out, 1, vertical sync, polarity set by SYNC_ACTIVE_LOW
- display_enable, out, 1, 1 when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_start, out, 1, one-cycle strobe when h_count == 0 while busy
- frame_start, out, 1, one-cycle strobe when h_count == 0 and v_count == 0 while busy

## Operation
- Top-level FSM has two states, IDLE and SCAN.
- Horizontal phase FSM: H_ACT (0..1023), H_FP (1024..1047), H_SY (1048..1183), H_BP (1184..1327).
- Vertical phase FSM: V_ACT (0..767), V_FP (768..770), V_SY (771..776), V_BP (777..805).
- IDLE:
  - Counters are held at 0, busy=0, display_enable=0, strobes=0.
  - Sync outputs sit at their inactive level.
  - When run is sampled 1, the FSM enters SCAN.
- SCAN: h_count increments every cycle.
  - At 1327, h_count wraps to 0 and v_count advances by 1.
  - v_count wraps 805 -> 0.
  - Each phase FSM changes state exactly at its boundary count. Phase state, not magnitude compares on the counters, drives the outputs.
- h_sync is active during H_SY in every line, including lines in vertical blanking.
- v_sync is active for every pixel of lines 771..776.
- Stop:
  - run is sampled only on the last pixel of a frame (h=1327, v=805).
  - If run=0 there, the FSM goes to IDLE; otherwise the counters wrap and the next frame begins.
  - Deasserting run mid-frame never truncates the frame.
- Counter arithmetic is modulo the line/frame totals. A counter never reaches the line or frame total (1328 or 806) and never exceeds it.

## Timing
- All outputs are registered. Every output in a given cycle describes the h_count/v_count values shown in that same cycle, so there is zero skew between coordinates and syncs.
- Reset (control_reset_n=0 at an edge):
  - The FSM returns to IDLE and both counters to 0.
  - busy, display_enable, line_start and frame_start go to 0.
  - h_sync and v_sync go inactive (1 when SYNC_ACTIVE_LOW=1).
  - This applies in any state, including mid-line and mid-sync-pulse.
- Start latency:
  - Edge N samples run=1 in IDLE.
  - From edge N onward: busy=1, h=0, v=0, frame_start=1, line_start=1, display_enable=1.
- If reset and run are both asserted, reset wins.
- Stop timing: after the edge ending pixel (1327,805) with run=0, the block is in IDLE (busy=0) on the next cycle.
- If run=1 at the last pixel, frame_start for the next frame follows with no gap cycle.
- Steady-state periods: line_start every 1328 cycles; frame_start every 1,070,368 cycles.

## Test plan
- Reset: hold control_reset_n=0 for 3 cycles with run=1 -> busy=0, h=v=0, h_sync=v_sync=1, display_enable=0, both strobes 0.
- Start: release reset, hold run=1 -> frame_start and line_start pulse on the first SCAN cycle. display_enable=1 for h 0..1023 and 0 at h=1024. h_sync low exactly for h 1048..1183 (136 cycles).
- Frame wrap: run continuously for 2 frames ->
  - v_sync low for exactly 6×1328 cycles per frame, starting at (0,771).
  - display_enable is never 1 at v ≥ 768.
  - frame_start spacing is 1,070,368 cycles.
- Stop: drop run at (500,300) -> scanning continues to (1327,805), then IDLE with busy=0. Re-raise run -> frame_start on the next cycle.
- Mid-sync reset: assert reset at (1100,773), during both sync pulses -> next cycle h=v=0, both syncs inactive, IDLE.
- Polarity: SYNC_ACTIVE_LOW=0 -> syncs idle at 0 and pulse high over the same windows.
